trap_csr_unit: RTL and testbench
================================

# trap_csr_unit

Machine-mode CSR file and trap responder for the single-cycle RV32I core. It consumes the decoder's CSR and exception requests (`csr_op`, `excRequest`, `excCause`, `excRet`, `inst_invalid`) and answers them. It holds mstatus/mie/mip/mtvec/mepc/mcause/mscratch/mcycle and the memory-mapped mtime/mtimecmp timer. It drives `exception_present`, `trap_vector` and `epc` back to the PC-source mux.

## Interface
Parameters:
- `MISA_VAL`, default 32'h4000_0100: read-only misa value (RV32I).
- `HART_ID`, default 0: mhartid value.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `instr_valid`  in  1  the current instruction retires this cycle unless trapped.
- `pc`  in  32  PC of the current instruction.
- `csr_op`  in  2  0 none, 1 write, 2 set, 3 clear.
- `csr_addr`  in  12  CSR address (instr[31:20]).
- `csr_wdata`  in  32  rs1 or zero-extended zimm, selected upstream by `csr_source`.
- `exc_request`  in  1  ECALL/EBREAK.
- `exc_cause`  in  32  cause accompanying `exc_request`/`inst_invalid`.
- `inst_invalid`  in  1  illegal instruction from the decoder.
- `exc_ret`  in  1  MRET.
- `mtimecmp_we`  in  1  store to mtimecmp.
- `mtimecmp_hi`  in  1  1 selects the upper word, 0 the lower word.
- `mtimecmp_wdata`  in  32  store data.
- `csr_rdata`  out  32  old CSR value for rd; combinational.
- `exception_present`  out  1  take the trap this cycle; combinational.
- `trap_vector`  out  32  mtvec, bits[1:0] = 0.
- `epc`  out  32  mepc.
- `mtime`  out  64  timer value, for `mem_from_mtime` loads.

## Operation
Implemented CSRs, with reset values:
- mstatus 0x300: only MIE[3] and MPIE[7] are writable; reset 0.
- misa 0x301: reads `MISA_VAL`; writes ignored.
- mie 0x304: only MTIE[7] writable; reset 0.
- mtvec 0x305: direct mode only, bits[1:0] read 0; reset 0.
- mscratch 0x340: reset 0.
- mepc 0x341: bits[1:0] read 0; reset 0.
- mcause 0x342: reset 0.
- mip 0x344: read-only, MTIP[7] = timer pending.
- mcycle 0xB00 / mcycleh 0xB80: 64-bit, reset 0.
- mhartid 0xF14: reads `HART_ID`.

CSR access rules:
- `csr_rdata` = current value at `csr_addr` whenever `csr_op` != 0, else 0.
- Write value: write = wdata; set = old | wdata; clear = old & ~wdata.
- Any write to read-only misa, mip or mhartid is ignored; no trap.
- Unimplemented address with `csr_op` != 0 is an illegal access: `exception_present` = 1, cause 2, no register change, `csr_rdata` = 0.

Trap sources, in priority order (first wins):
1. `inst_invalid`, or an illegal CSR access: cause = 2 for the CSR case, otherwise `exc_cause`.
2. `exc_request`: cause = `exc_cause`.
3. Timer interrupt: mstatus.MIE & mie.MTIE & MTIP. Cause = 32'h8000_0007.
4. `exc_ret`: not a trap.

A trap fires only when `instr_valid` = 1.

On a trap, at the clock edge:
- mepc ← `pc`; mcause ← cause.
- MPIE ← MIE; MIE ← 0.
- The instruction's own CSR write is suppressed.

On MRET (no trap that cycle): MIE ← MPIE, MPIE ← 1.

Timer behaviour:
- mtime increments by 1 every cycle.
- mtimecmp resets to 64'hFFFF_FFFF_FFFF_FFFF.
- MTIP is registered: MTIP ← (mtime >= mtimecmp), evaluated on the post-update values.
- mcycle increments every cycle and wraps at 2^64. A CSR write to either half that cycle replaces the increment for that half; the other half still counts.

## Timing
- Single-cycle: all register updates occur at the same edge that retires the instruction.
- `exception_present` and `csr_rdata` are combinational from the current inputs and state.
- `trap_vector` and `epc` are register outputs. An MRET following a mepc write sees the new value next cycle.
- A write that sets MIE or MTIE while MTIP = 1 causes the interrupt on the next valid instruction, never the writing one.
- `mtimecmp` write: MTIP reflects the new compare value one cycle later.
- `rst_n` = 0 at any edge forces every register to its reset value. This holds even mid-trap, and overrides increments and writes.
- After reset, `exception_present` = 0 until an input requests a trap.

## Structure
- Add to `Common`: CSR address localparams, the `csr_op_e` enum (NONE/WRITE/SET/CLEAR), and cause constants (CAUSE_ILLEGAL = 2, CAUSE_BREAK = 3, CAUSE_ECALL_M = 11, CAUSE_MTIMER = 32'h8000_0007).
- Sub-module `mtime_timer` holds mtime, mtimecmp and the registered MTIP. It exports `mtime` and `mtip`.

## Test plan
- Reset, then read each CSR: mstatus/mie/mtvec/mepc/mcause/mscratch read 0, misa reads 32'h4000_0100, mhartid reads 0, mtime counts from 0.
- CSRRW mtvec ← 32'h0000_0103: reads 32'h0000_0100. ECALL at pc 0x80 with cause 11: `exception_present` = 1; next cycle mepc = 0x80, mcause = 11, MIE = 0.
- mstatus = 0x8 then MRET: MIE = 0, MPIE = 1 after MRET; then CSRRS mstatus 0x8 followed by CSRRC mstatus 0x8 → 0x80.
- mtimecmp = 10, MTIE = 1, MIE = 1: first valid instruction after MTIP rises traps with mcause 32'h8000_0007 and mepc = that pc. With MIE = 0 there is no trap.
- CSRRW to 0x7C0 (unimplemented): trap, cause 2, `csr_rdata` = 0, no state change. CSR write and `inst_invalid` in the same cycle: the write is suppressed.
- mcycle = 32'hFFFF_FFFF: next cycle mcycleh increments. Assert `rst_n` = 0 during a trap cycle: mepc, mcause and mstatus all read 0 afterwards.

Source files
------------

// File: rtl/trap_csr_unit_pkg.sv
// rtl/trap_csr_unit_pkg.sv - CSR addresses, op encoding, trap causes and the CSR write helper.
package trap_csr_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_BREAK   = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] CAUSE_MTIMER  = 32'h8000_0007;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIE_MTIE_BIT     = 7;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0080;
  localparam logic [31:0] ADDR_MASK     = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_val,
                                            logic [31:0] wdata);
    case (op)
      CSR_OP_WRITE: return wdata;
      CSR_OP_SET:   return old_val | wdata;
      CSR_OP_CLEAR: return old_val & ~wdata;
      default:      return old_val;
    endcase
  endfunction

endpackage

// File: rtl/trap_csr_unit_if.sv
// rtl/trap_csr_unit_if.sv - decoder-to-CSR request bus and trap/CSR responses.
interface trap_csr_unit_if;
  import trap_csr_unit_pkg::*;

  logic        instr_valid;
  logic [31:0] pc;
  csr_op_e     csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        exc_request;
  logic [31:0] exc_cause;
  logic        inst_invalid;
  logic        exc_ret;
  logic        mtimecmp_we;
  logic        mtimecmp_hi;
  logic [31:0] mtimecmp_wdata;

  logic [31:0] csr_rdata;
  logic        exception_present;
  logic [31:0] trap_vector;
  logic [31:0] epc;
  logic [63:0] mtime;

  modport master (
    output instr_valid, pc, csr_op, csr_addr, csr_wdata, exc_request, exc_cause,
           inst_invalid, exc_ret, mtimecmp_we, mtimecmp_hi, mtimecmp_wdata,
    input  csr_rdata, exception_present, trap_vector, epc, mtime
  );

  modport slave (
    input  instr_valid, pc, csr_op, csr_addr, csr_wdata, exc_request, exc_cause,
           inst_invalid, exc_ret, mtimecmp_we, mtimecmp_hi, mtimecmp_wdata,
    output csr_rdata, exception_present, trap_vector, epc, mtime
  );

endinterface

// File: rtl/trap_csr_unit_mtime_timer.sv
// rtl/trap_csr_unit_mtime_timer.sv - free-running mtime, mtimecmp and registered MTIP.
module mtime_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmp_we_i,
  input  logic        cmp_hi_i,
  input  logic [31:0] cmp_wdata_i,
  output logic [63:0] mtime_o,
  output logic        mtip_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        mtip_q;

  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    if (cmp_we_i) begin
      if (cmp_hi_i) mtimecmp_d[63:32] = cmp_wdata_i;
      else          mtimecmp_d[31:0]  = cmp_wdata_i;
    end
  end

  // Compare the post-update values so a new mtimecmp shows up in MTIP one cycle later.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= (mtime_d >= mtimecmp_d);
    end
  end

  assign mtime_o = mtime_q;
  assign mtip_o  = mtip_q;

endmodule

// File: rtl/trap_csr_unit.sv
// rtl/trap_csr_unit.sv - machine-mode CSR file and trap responder for the single-cycle core.
module trap_csr_unit
  import trap_csr_unit_pkg::*;
#(
  parameter logic [31:0] MISA_VAL = 32'h4000_0100,
  parameter logic [31:0] HART_ID  = 32'd0
) (
  input logic               clk,
  input logic               rst_n,
  trap_csr_unit_if.slave    bus
);

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;

  logic [63:0] mtime_w;
  logic        mtip;

  logic        csr_active;
  logic        addr_hit;
  logic        illegal_csr;
  logic [31:0] old_val;
  logic [31:0] wval;
  logic        timer_irq;
  logic        trap;
  logic [31:0] cause;
  logic        csr_we;
  logic        mret;

  mtime_timer u_timer (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmp_we_i    (bus.mtimecmp_we),
    .cmp_hi_i    (bus.mtimecmp_hi),
    .cmp_wdata_i (bus.mtimecmp_wdata),
    .mtime_o     (mtime_w),
    .mtip_o      (mtip)
  );

  always_comb begin
    addr_hit = 1'b1;
    old_val  = 32'd0;
    case (bus.csr_addr)
      CSR_MSTATUS:  old_val = mstatus_q;
      CSR_MISA:     old_val = MISA_VAL;
      CSR_MIE:      old_val = mie_q;
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
      CSR_MIP:      old_val = {24'd0, mtip, 7'd0};
      CSR_MCYCLE:   old_val = mcycle_q[31:0];
      CSR_MCYCLEH:  old_val = mcycle_q[63:32];
      CSR_MHARTID:  old_val = HART_ID;
      default:      addr_hit = 1'b0;
    endcase
  end

  assign csr_active  = (bus.csr_op != CSR_OP_NONE);
  assign illegal_csr = csr_active && !addr_hit;
  assign wval        = csr_apply(bus.csr_op, old_val, bus.csr_wdata);
  assign timer_irq   = mstatus_q[MSTATUS_MIE_BIT] & mie_q[MIE_MTIE_BIT] & mtip;
  assign trap        = bus.instr_valid &
                       (bus.inst_invalid | illegal_csr | bus.exc_request | timer_irq);
  assign csr_we      = bus.instr_valid && csr_active && addr_hit && !trap;
  assign mret        = bus.instr_valid && bus.exc_ret && !trap;

  always_comb begin
    if (bus.inst_invalid)     cause = bus.exc_cause;
    else if (illegal_csr)     cause = CAUSE_ILLEGAL;
    else if (bus.exc_request) cause = bus.exc_cause;
    else                      cause = CAUSE_MTIMER;
  end

  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + 64'd1;

    // Read-only CSRs fall through the default arm, so writes to them are silently dropped.
    if (csr_we) begin
      case (bus.csr_addr)
        CSR_MSTATUS:  mstatus_d         = wval & MSTATUS_WMASK;
        CSR_MIE:      mie_d             = wval & MIE_WMASK;
        CSR_MTVEC:    mtvec_d           = wval & ADDR_MASK;
        CSR_MSCRATCH: mscratch_d        = wval;
        CSR_MEPC:     mepc_d            = wval & ADDR_MASK;
        CSR_MCAUSE:   mcause_d          = wval;
        CSR_MCYCLE:   mcycle_d[31:0]    = wval;
        CSR_MCYCLEH:  mcycle_d[63:32]   = wval;
        default:      ;
      endcase
    end

    if (trap) begin
      mepc_d                      = bus.pc & ADDR_MASK;
      mcause_d                    = cause;
      mstatus_d[MSTATUS_MPIE_BIT] = mstatus_q[MSTATUS_MIE_BIT];
      mstatus_d[MSTATUS_MIE_BIT]  = 1'b0;
    end else if (mret) begin
      mstatus_d[MSTATUS_MIE_BIT]  = mstatus_q[MSTATUS_MPIE_BIT];
      mstatus_d[MSTATUS_MPIE_BIT] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_q  <= 32'd0;
      mie_q      <= 32'd0;
      mtvec_q    <= 32'd0;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mcycle_q   <= 64'd0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
    end
  end

  assign bus.csr_rdata         = (csr_active && addr_hit) ? old_val : 32'd0;
  assign bus.exception_present = trap;
  assign bus.trap_vector       = mtvec_q;
  assign bus.epc               = mepc_q;
  assign bus.mtime             = mtime_w;

endmodule

// File: tb/tb_trap_csr_unit.sv
// tb/tb_trap_csr_unit.sv - directed scenario bench for trap_csr_unit.
module tb_trap_csr_unit;
  import trap_csr_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  trap_csr_unit_if bus ();

  trap_csr_unit #(.MISA_VAL(32'h4000_0100), .HART_ID(32'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  task automatic idle();
    bus.instr_valid    = 1'b0;
    bus.pc             = 32'd0;
    bus.csr_op         = CSR_OP_NONE;
    bus.csr_addr       = 12'd0;
    bus.csr_wdata      = 32'd0;
    bus.exc_request    = 1'b0;
    bus.exc_cause      = 32'd0;
    bus.inst_invalid   = 1'b0;
    bus.exc_ret        = 1'b0;
    bus.mtimecmp_we    = 1'b0;
    bus.mtimecmp_hi    = 1'b0;
    bus.mtimecmp_wdata = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Non-retiring read: instr_valid stays low so nothing is written.
  task automatic rd(input logic [11:0] addr);
    idle();
    bus.csr_op   = CSR_OP_SET;
    bus.csr_addr = addr;
    #1;
  endtask

  task automatic wr(input csr_op_e op, input logic [11:0] addr, input logic [31:0] data);
    idle();
    bus.instr_valid = 1'b1;
    bus.csr_op      = op;
    bus.csr_addr    = addr;
    bus.csr_wdata   = data;
    step();
    idle();
  endtask

  task automatic mtimecmp_write(input logic hi, input logic [31:0] data);
    idle();
    bus.mtimecmp_we    = 1'b1;
    bus.mtimecmp_hi    = hi;
    bus.mtimecmp_wdata = data;
    step();
    idle();
  endtask

  task automatic test_reset();
    logic [11:0] addrs [8];
    logic [31:0] exps  [8];
    addrs = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MSCRATCH,
              CSR_MISA, CSR_MHARTID};
    exps  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h4000_0100, 32'd0};
    apply_reset();
    checks++; if (bus.mtime !== 64'd0) begin errors++; $display("FAIL rst_mtime0 got=%h exp=%h", bus.mtime, 64'd0); end
    checks++; if (bus.exception_present !== 1'b0) begin errors++; $display("FAIL rst_exc got=%b exp=0", bus.exception_present); end
    for (int i = 0; i < 8; i++) begin
      rd(addrs[i]);
      checks++; if (bus.csr_rdata !== exps[i]) begin errors++; $display("FAIL rst_csr_%h got=%h exp=%h", addrs[i], bus.csr_rdata, exps[i]); end
    end
    idle();
    #1;
    checks++; if (bus.csr_rdata !== 32'd0) begin errors++; $display("FAIL rdata_no_op got=%h exp=0", bus.csr_rdata); end
    step();
    checks++; if (bus.mtime !== 64'd1) begin errors++; $display("FAIL rst_mtime1 got=%h exp=%h", bus.mtime, 64'd1); end
  endtask

  task automatic test_mtvec_ecall();
    wr(CSR_OP_WRITE, CSR_MTVEC, 32'h0000_0103);
    rd(CSR_MTVEC);
    checks++; if (bus.csr_rdata !== 32'h0000_0100) begin errors++; $display("FAIL mtvec_rd got=%h exp=%h", bus.csr_rdata, 32'h100); end
    checks++; if (bus.trap_vector !== 32'h0000_0100) begin errors++; $display("FAIL trap_vector got=%h exp=%h", bus.trap_vector, 32'h100); end
    wr(CSR_OP_WRITE, CSR_MSTATUS, 32'h8);
    idle();
    bus.instr_valid = 1'b1;
    bus.pc          = 32'h80;
    bus.exc_request = 1'b1;
    bus.exc_cause   = CAUSE_ECALL_M;
    #1;
    checks++; if (bus.exception_present !== 1'b1) begin errors++; $display("FAIL ecall_exc got=%b exp=1", bus.exception_present); end
    step();
    idle();
    #1;
    checks++; if (bus.epc !== 32'h80) begin errors++; $display("FAIL ecall_epc got=%h exp=%h", bus.epc, 32'h80); end
    rd(CSR_MCAUSE);
    checks++; if (bus.csr_rdata !== 32'd11) begin errors++; $display("FAIL ecall_mcause got=%h exp=%h", bus.csr_rdata, 32'd11); end
    rd(CSR_MSTATUS);
    checks++; if (bus.csr_rdata !== 32'h80) begin errors++; $display("FAIL ecall_mstatus got=%h exp=%h", bus.csr_rdata, 32'h80); end
  endtask

  task automatic test_mret();
    wr(CSR_OP_WRITE, CSR_MSTATUS, 32'h8);
    idle();
    bus.instr_valid = 1'b1;
    bus.exc_ret     = 1'b1;
    #1;
    checks++; if (bus.exception_present !== 1'b0) begin errors++; $display("FAIL mret_exc got=%b exp=0", bus.exception_present); end
    step();
    rd(CSR_MSTATUS);
    checks++; if (bus.csr_rdata !== 32'h80) begin errors++; $display("FAIL mret_mstatus got=%h exp=%h", bus.csr_rdata, 32'h80); end
    wr(CSR_OP_SET, CSR_MSTATUS, 32'h8);
    rd(CSR_MSTATUS);
    checks++; if (bus.csr_rdata !== 32'h88) begin errors++; $display("FAIL csrrs_mstatus got=%h exp=%h", bus.csr_rdata, 32'h88); end
    idle();
    bus.instr_valid = 1'b1;
    bus.csr_op      = CSR_OP_CLEAR;
    bus.csr_addr    = CSR_MSTATUS;
    bus.csr_wdata   = 32'h8;
    #1;
    checks++; if (bus.csr_rdata !== 32'h88) begin errors++; $display("FAIL csrrc_old got=%h exp=%h", bus.csr_rdata, 32'h88); end
    step();
    rd(CSR_MSTATUS);
    checks++; if (bus.csr_rdata !== 32'h80) begin errors++; $display("FAIL csrrc_mstatus got=%h exp=%h", bus.csr_rdata, 32'h80); end
    wr(CSR_OP_WRITE, CSR_MEPC, 32'h203);
    #1;
    checks++; if (bus.epc !== 32'h200) begin errors++; $display("FAIL mepc_wr got=%h exp=%h", bus.epc, 32'h200); end
  endtask

  task automatic test_timer();
    apply_reset();
    wr(CSR_OP_WRITE, CSR_MIE, 32'hFFFF_FFFF);
    rd(CSR_MIE);
    checks++; if (bus.csr_rdata !== 32'h80) begin errors++; $display("FAIL mie_mask got=%h exp=%h", bus.csr_rdata, 32'h80); end
    mtimecmp_write(1'b1, 32'd0);
    mtimecmp_write(1'b0, 32'd10);
    for (int i = 0; i < 50 && bus.mtime != 64'd9; i++) step();
    checks++; if (bus.mtime !== 64'd9) begin errors++; $display("FAIL timer_wait got=%h exp=%h", bus.mtime, 64'd9); end
    rd(CSR_MIP);
    checks++; if (bus.csr_rdata !== 32'd0) begin errors++; $display("FAIL mip_before got=%h exp=0", bus.csr_rdata); end
    step();
    rd(CSR_MIP);
    checks++; if (bus.csr_rdata !== 32'h80) begin errors++; $display("FAIL mip_after got=%h exp=%h", bus.csr_rdata, 32'h80); end
    idle();
    bus.instr_valid = 1'b1;
    bus.pc          = 32'h2FC;
    bus.csr_op      = CSR_OP_SET;
    bus.csr_addr    = CSR_MSTATUS;
    bus.csr_wdata   = 32'h8;
    #1;
    checks++; if (bus.exception_present !== 1'b0) begin errors++; $display("FAIL irq_on_writer got=%b exp=0", bus.exception_present); end
    step();
    idle();
    bus.instr_valid = 1'b1;
    bus.pc          = 32'h300;
    #1;
    checks++; if (bus.exception_present !== 1'b1) begin errors++; $display("FAIL irq_take got=%b exp=1", bus.exception_present); end
    step();
    rd(CSR_MCAUSE);
    checks++; if (bus.csr_rdata !== 32'h8000_0007) begin errors++; $display("FAIL irq_mcause got=%h exp=%h", bus.csr_rdata, 32'h8000_0007); end
    checks++; if (bus.epc !== 32'h300) begin errors++; $display("FAIL irq_epc got=%h exp=%h", bus.epc, 32'h300); end
    idle();
    bus.instr_valid = 1'b1;
    bus.pc          = 32'h304;
    #1;
    checks++; if (bus.exception_present !== 1'b0) begin errors++; $display("FAIL irq_mie0 got=%b exp=0", bus.exception_present); end
    step();
    idle();
  endtask

  task automatic test_illegal();
    wr(CSR_OP_WRITE, CSR_MSCRATCH, 32'hA5A5);
    rd(12'h7C0);
    checks++; if (bus.exception_present !== 1'b0) begin errors++; $display("FAIL ill_novalid got=%b exp=0", bus.exception_present); end
    idle();
    bus.instr_valid = 1'b1;
    bus.pc          = 32'h400;
    bus.csr_op      = CSR_OP_WRITE;
    bus.csr_addr    = 12'h7C0;
    bus.csr_wdata   = 32'hFFFF;
    #1;
    checks++; if (bus.exception_present !== 1'b1) begin errors++; $display("FAIL ill_exc got=%b exp=1", bus.exception_present); end
    checks++; if (bus.csr_rdata !== 32'd0) begin errors++; $display("FAIL ill_rdata got=%h exp=0", bus.csr_rdata); end
    step();
    rd(CSR_MCAUSE);
    checks++; if (bus.csr_rdata !== 32'd2) begin errors++; $display("FAIL ill_mcause got=%h exp=2", bus.csr_rdata); end
    rd(CSR_MSCRATCH);
    checks++; if (bus.csr_rdata !== 32'hA5A5) begin errors++; $display("FAIL ill_mscratch got=%h exp=%h", bus.csr_rdata, 32'hA5A5); end
    idle();
    bus.instr_valid  = 1'b1;
    bus.pc           = 32'h404;
    bus.csr_op       = CSR_OP_WRITE;
    bus.csr_addr     = CSR_MSCRATCH;
    bus.csr_wdata    = 32'h1234;
    bus.inst_invalid = 1'b1;
    bus.exc_cause    = CAUSE_ILLEGAL;
    #1;
    checks++; if (bus.exception_present !== 1'b1) begin errors++; $display("FAIL inv_exc got=%b exp=1", bus.exception_present); end
    step();
    rd(CSR_MSCRATCH);
    checks++; if (bus.csr_rdata !== 32'hA5A5) begin errors++; $display("FAIL inv_suppress got=%h exp=%h", bus.csr_rdata, 32'hA5A5); end
    checks++; if (bus.epc !== 32'h404) begin errors++; $display("FAIL inv_epc got=%h exp=%h", bus.epc, 32'h404); end
    idle();
    bus.instr_valid = 1'b1;
    bus.csr_op      = CSR_OP_WRITE;
    bus.csr_addr    = CSR_MISA;
    #1;
    checks++; if (bus.exception_present !== 1'b0) begin errors++; $display("FAIL misa_wr_exc got=%b exp=0", bus.exception_present); end
    step();
    rd(CSR_MISA);
    checks++; if (bus.csr_rdata !== 32'h4000_0100) begin errors++; $display("FAIL misa_ro got=%h exp=%h", bus.csr_rdata, 32'h4000_0100); end
  endtask

  task automatic test_mcycle();
    apply_reset();
    wr(CSR_OP_WRITE, CSR_MCYCLE, 32'hFFFF_FFFF);
    rd(CSR_MCYCLE);
    checks++; if (bus.csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_wr got=%h exp=%h", bus.csr_rdata, 32'hFFFF_FFFF); end
    rd(CSR_MCYCLEH);
    checks++; if (bus.csr_rdata !== 32'd0) begin errors++; $display("FAIL mcycleh_pre got=%h exp=0", bus.csr_rdata); end
    step();
    rd(CSR_MCYCLE);
    checks++; if (bus.csr_rdata !== 32'd0) begin errors++; $display("FAIL mcycle_wrap got=%h exp=0", bus.csr_rdata); end
    rd(CSR_MCYCLEH);
    checks++; if (bus.csr_rdata !== 32'd1) begin errors++; $display("FAIL mcycleh_inc got=%h exp=1", bus.csr_rdata); end
  endtask

  task automatic test_reset_mid_trap();
    wr(CSR_OP_WRITE, CSR_MSTATUS, 32'h8);
    wr(CSR_OP_WRITE, CSR_MEPC, 32'h44);
    wr(CSR_OP_WRITE, CSR_MCAUSE, 32'd5);
    idle();
    bus.instr_valid = 1'b1;
    bus.pc          = 32'h500;
    bus.exc_request = 1'b1;
    bus.exc_cause   = CAUSE_BREAK;
    rst_n           = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    #1;
    checks++; if (bus.epc !== 32'd0) begin errors++; $display("FAIL rtrap_epc got=%h exp=0", bus.epc); end
    checks++; if (bus.exception_present !== 1'b0) begin errors++; $display("FAIL rtrap_exc got=%b exp=0", bus.exception_present); end
    rd(CSR_MCAUSE);
    checks++; if (bus.csr_rdata !== 32'd0) begin errors++; $display("FAIL rtrap_mcause got=%h exp=0", bus.csr_rdata); end
    rd(CSR_MSTATUS);
    checks++; if (bus.csr_rdata !== 32'd0) begin errors++; $display("FAIL rtrap_mstatus got=%h exp=0", bus.csr_rdata); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_mtvec_ecall();
    test_mret();
    test_timer();
    test_illegal();
    test_mcycle();
    test_reset_mid_trap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
